// File: rtl/edge_writer_pkg.sv
// Shared widths and FSM state encoding for the edge-matrix write path.
package edge_writer_pkg;

    localparam int unsigned DEFAULT_MAX_NODES   = 128;
    localparam int unsigned DEFAULT_INDEX_WIDTH = 8;
    localparam int unsigned DEFAULT_VALUE_WIDTH = 16;
    localparam int unsigned DEFAULT_MADDR_WIDTH = 16;
    localparam int unsigned DEFAULT_MDATA_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrite,
        StRelease,
        StVerify,
        StVerifyRelease
    } ew_state_e;

endpackage

// File: rtl/edge_writer_fifo.sv
// Request queue for edge writes: power-of-two depth, extra pointer bit tells full from empty.
module edge_writer_fifo
    import edge_writer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/edge_writer.sv
// Queues (from,to,value) edge writes and drives them onto the shared BlockRam bus.
// Define EDGE_WRITER_VERIFY_EN to add a readback check after every write.
module edge_writer
    import edge_writer_pkg::*;
#(
    parameter int unsigned MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int unsigned VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] base_address,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [INDEX_WIDTH-1:0] req_from,
    input  logic [INDEX_WIDTH-1:0] req_to,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output wire logic [MADDR_WIDTH-1:0] mem_addr,
    output wire logic [MDATA_WIDTH-1:0] mem_write_data,
    output wire logic              mem_write_enable,
    input  logic                   mem_write_ready,
    output wire logic              mem_read_enable,
    input  logic                   mem_read_ready,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic                   busy,
    output logic                   done,
    output logic                   range_error,
    output logic                   verify_error
);

    localparam int unsigned EntryW    = 2 * INDEX_WIDTH + VALUE_WIDTH;
    localparam int unsigned WordBytes = MADDR_WIDTH / 8;

    ew_state_e state_q, state_d;

    logic [MADDR_WIDTH-1:0] base_q;
    logic [INDEX_WIDTH-1:0] n_q;
    logic                   push, pop, fifo_full, fifo_empty;
    logic [EntryW-1:0]      head;
    logic [INDEX_WIDTH-1:0] head_from, head_to, cur_from_q, cur_to_q;
    logic [VALUE_WIDTH-1:0] head_value;
    logic [MDATA_WIDTH-1:0] data_q;
    logic [MADDR_WIDTH-1:0] addr_q, offset;
    logic                   head_bad, load_cur, try_pop, done_c, range_error_c;
    logic                   write_own;

    assign req_ready = !reset && !fifo_full;
    assign push      = req_valid && req_ready;

    edge_writer_fifo #(
        .WIDTH(EntryW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data({req_from, req_to, req_value}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign {head_from, head_to, head_value} = head;
    assign head_bad = (head_from >= n_q) || (head_to >= n_q) || (32'(head_from) >= MAX_NODES);

    // All terms at MADDR_WIDTH so the product wraps modulo the address space.
    assign offset = (MADDR_WIDTH'(cur_from_q) * MADDR_WIDTH'(n_q) + MADDR_WIDTH'(cur_to_q))
                    * MADDR_WIDTH'(WordBytes);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= base_address;
            n_q     <= number_of_nodes;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (load_cur) begin
            cur_from_q <= head_from;
            cur_to_q   <= head_to;
            data_q     <= MDATA_WIDTH'(head_value);
        end
        if (state_q == StAddr) addr_q <= base_q + offset;
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        load_cur      = 1'b0;
        try_pop       = 1'b0;
        done_c        = 1'b0;
        range_error_c = 1'b0;
        unique case (state_q)
            StIdle:  try_pop = 1'b1;
            StAddr:  state_d = StWrite;
            StWrite: if (mem_write_ready) state_d = StRelease;
`ifdef EDGE_WRITER_VERIFY_EN
            StRelease: state_d = StVerify;
            StVerify:  if (mem_read_ready) state_d = StVerifyRelease;
            StVerifyRelease: begin
                done_c  = 1'b1;
                try_pop = 1'b1;
            end
`else
            StRelease: begin
                done_c  = 1'b1;
                try_pop = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
        // Dispatching straight out of a release cycle keeps throughput at one write per 3 cycles.
        if (try_pop) begin
            state_d = StIdle;
            if (!fifo_empty) begin
                pop = 1'b1;
                if (head_bad) begin
                    range_error_c = 1'b1;
                end else begin
                    load_cur = 1'b1;
                    state_d  = StAddr;
                end
            end
        end
    end

    assign done        = done_c && !reset;
    assign range_error = range_error_c && !reset;
    assign busy        = !reset && (!fifo_empty || state_q != StIdle);
    assign write_own   = !reset && (state_q == StWrite);

    assign mem_write_data   = write_own ? data_q : 'z;
    assign mem_write_enable = write_own ? 1'b1 : 1'bz;

`ifdef EDGE_WRITER_VERIFY_EN
    logic read_own;
    logic verify_q;

    assign read_own = !reset && (state_q == StVerify);

    always_ff @(posedge clock) begin
        if (reset) begin
            verify_q <= 1'b0;
        end else if (state_q == StVerify && mem_read_ready && mem_read_data != data_q) begin
            verify_q <= 1'b1;
        end
    end

    assign mem_addr        = (write_own || read_own) ? addr_q : 'z;
    assign mem_read_enable = read_own ? 1'b1 : 1'bz;
    assign verify_error    = verify_q;
`else
    logic unused_read;

    assign unused_read     = ^{mem_read_ready, mem_read_data};
    assign mem_addr        = write_own ? addr_q : 'z;
    assign mem_read_enable = 1'bz;
    assign verify_error    = 1'b0;
`endif

endmodule

// File: tb/tb_edge_writer.sv
// Directed bench for edge_writer with a small BlockRam model on the bus.
// Covers the EDGE_WRITER_VERIFY_EN build as well when that macro is defined.
module tb_edge_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] base_address;
    logic [7:0]  number_of_nodes;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_from;
    logic [7:0]  req_to;
    logic [15:0] req_value;
    wire  [15:0] mem_addr;
    wire  [15:0] mem_write_data;
    wire         mem_write_enable;
    logic        mem_write_ready;
    wire         mem_read_enable;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        busy;
    logic        done;
    logic        range_error;
    logic        verify_error;

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    logic corrupt = 1'b0;
    logic [15:0] ram [65536];

`ifdef EDGE_WRITER_VERIFY_EN
    localparam int DoneLat = 6;
`else
    localparam int DoneLat = 4;
`endif

    edge_writer u_dut (
        .clock           (clock),
        .reset           (reset),
        .base_address    (base_address),
        .number_of_nodes (number_of_nodes),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_from        (req_from),
        .req_to          (req_to),
        .req_value       (req_value),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_write_ready (mem_write_ready),
        .mem_read_enable (mem_read_enable),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .busy            (busy),
        .done            (done),
        .range_error     (range_error),
        .verify_error    (verify_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write_enable === 1'b1 && mem_write_ready) ram[mem_addr] <= mem_write_data;
        if (done) done_count <= done_count + 1;
    end

    assign mem_read_data = ram[mem_addr] ^ ((corrupt && mem_addr == 16'h0070) ? 16'h0001 : 16'h0000);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int f, input int t, input int v);
        int ok = 0;
        @(posedge clock);
        #1;
        req_from  = 8'(f);
        req_to    = 8'(t);
        req_value = 16'(v);
        req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (ok == 0) check_eq("send_ready", 0, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_from  = 8'd7;
        req_to    = 8'd9;
        req_value = 16'hffff;
    endtask

    task automatic wait_write(input string tag, input logic [15:0] addr, input logic [15:0] data);
        int ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (mem_write_enable === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check_eq({tag, "_we"}, ok, 1);
        check_eq({tag, "_addr"}, mem_addr, addr);
        check_eq({tag, "_data"}, mem_write_data, data);
    endtask

    task automatic wait_idle(input string tag);
        int ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check_eq(tag, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int idx;
        int d0;
        logic r;
        logic seen;

        reset           = 1'b1;
        base_address    = 16'h0034;
        number_of_nodes = 8'd14;
        req_valid       = 1'b0;
        req_from        = '0;
        req_to          = '0;
        req_value       = '0;
        mem_write_ready = 1'b1;
        mem_read_ready  = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_range_error", range_error, 0);
        check_eq("rst_verify_error", verify_error, 0);
        check_eq("rst_we", mem_write_enable === 1'b1, 0);

        // New base/N after reset falls must be ignored.
        @(posedge clock);
        #1;
        reset           = 1'b0;
        base_address    = 16'd87;
        number_of_nodes = 8'd105;
        @(negedge clock);
        check_eq("post_rst_req_ready", req_ready, 1);

        // (3,5,15): 0x34 + (3*14+5)*2 = 0x92, done DoneLat cycles after accept.
        send(3, 5, 15);
        for (int k = 1; k <= DoneLat; k++) begin
            @(negedge clock);
            if (k == 3) begin
                check_eq("lat_we", mem_write_enable === 1'b1, 1);
                check_eq("lat_addr", mem_addr, 16'h0092);
                check_eq("lat_data", mem_write_data, 16'd15);
            end
            if (k < DoneLat) check_eq($sformatf("lat_no_done_%0d", k), done, 0);
        end
        check_eq("lat_done", done, 1);
        check_eq("lat_done_we_off", mem_write_enable === 1'b1, 0);
        wait_idle("lat_idle");

        // Out-of-range row is dropped without touching the bus.
        send(14, 0, 7);
        @(negedge clock);
        check_eq("range_pulse", range_error, 1);
        check_eq("range_we_off", mem_write_enable === 1'b1, 0);
        check_eq("range_no_done", done, 0);
        @(negedge clock);
        check_eq("range_pulse_end", range_error, 0);
        check_eq("range_busy", busy, 0);
        send(13, 13, 9);
        wait_write("after_range", 16'h01ba, 16'd9);
        wait_idle("after_range_idle");

        // Stalled bus: one entry in flight plus four queued before req_ready drops.
        mem_write_ready = 1'b0;
        d0  = done_count;
        acc = 0;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_from  = 8'd0;
        req_to    = 8'd0;
        req_value = 16'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            r = req_ready;
            @(posedge clock);
            if (r) acc++;
            #1;
            req_to    = 8'(acc);
            req_value = 16'(acc + 1);
        end
        check_eq("full_accepts", acc, 5);
        check_eq("full_req_ready", req_ready, 0);
        req_valid       = 1'b0;
        mem_write_ready = 1'b1;
        wait_idle("full_idle");
        check_eq("full_dones", done_count - d0, 5);
        check_eq("full_ram_0_4", ram[16'h003c], 16'd5);

        // Fill the whole 14x14 matrix with row*col, back to back.
        d0  = done_count;
        idx = 0;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_from  = 8'd0;
        req_to    = 8'd0;
        req_value = 16'd0;
        for (int cyc = 0; cyc < 3000 && idx < 196; cyc++) begin
            @(negedge clock);
            r = req_ready;
            @(posedge clock);
            if (r) idx++;
            #1;
            req_from  = 8'(idx / 14);
            req_to    = 8'(idx % 14);
            req_value = 16'((idx / 14) * (idx % 14));
            if (idx >= 196) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check_eq("fill_accepted", idx, 196);
        wait_idle("fill_idle");
        check_eq("fill_dones", done_count - d0, 196);
        for (int row = 0; row < 14; row++) begin
            for (int col = 0; col < 14; col++) begin
                check_eq($sformatf("fill_%0d_%0d", row, col),
                         ram[16'(52 + (row * 14 + col) * 2)], 16'(row * col));
            end
        end
        check_eq("fill_verify_error", verify_error, 0);

`ifdef EDGE_WRITER_VERIFY_EN
        // Corrupted readback of (2,2) at 0x70 sets the sticky flag.
        corrupt = 1'b1;
        send(2, 2, 4);
        wait_idle("verify_idle");
        check_eq("verify_set", verify_error, 1);
        corrupt = 1'b0;
        send(0, 0, 1);
        wait_idle("verify_idle2");
        check_eq("verify_sticky", verify_error, 1);
`endif

        // Reset while a write is stalled: bus released, queue dropped, no done.
        mem_write_ready = 1'b0;
        send(1, 1, 5);
        send(1, 2, 6);
        wait_write("pre_abort", 16'h0034 + 16'd30, 16'd5);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_we_off", mem_write_enable === 1'b1, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_req_ready", req_ready, 0);
        @(posedge clock);
        #1;
        reset           = 1'b0;
        mem_write_ready = 1'b1;
        d0   = done_count;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (mem_write_enable === 1'b1 || busy) seen = 1'b1;
        end
        check_eq("abort_queue_dropped", seen, 0);
        check_eq("abort_no_done", done_count - d0, 0);
        check_eq("abort_verify_cleared", verify_error, 0);

        // That reset latched base=87, N=105: (1,2) -> 87 + 107*2 = 0x12d.
        send(1, 2, 3);
        wait_write("new_base", 16'h012d, 16'd3);
        wait_idle("new_base_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
